// File: rtl/cam_pkg.sv
// Shared types for the camera stream ingest block: capture FSM states and
// the per-pixel frame tags carried through the output buffer.
package cam_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_SOF = 2'd0,
        ST_ACTIVE   = 2'd1,
        ST_DROP     = 2'd2
    } cam_state_t;

    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } cam_tag_t;

endpackage

// File: rtl/cam_fifo.sv
// First-word-fall-through FIFO: the head entry is presented combinationally,
// so a word pushed at edge N is visible right after edge N.
module cam_fifo #(
    parameter int WIDTH = 27,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (level == FULL_LVL);
    assign empty    = (level == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    // Storage is not reset; an empty buffer presents zeros instead.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/camera_stream_in.sv
// Camera pixel ingest: frames the incoming stream with sof/eol/eof tags,
// buffers it for a ready/valid consumer and reports overflow/short frames.
module camera_stream_in
    import cam_pkg::*;
#(
    parameter int PIX_W      = 24,
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [PIX_W-1:0]              pixel_data,
    input  logic                          pixel_valid,
    input  logic                          pixel_sof,
    output logic [PIX_W-1:0]              out_data,
    output logic                          out_sof,
    output logic                          out_eol,
    output logic                          out_eof,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   frame_count,
    output logic                          err_overflow,
    output logic                          err_short,
    input  logic                          err_clear
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    cam_state_t       state_q, state_d;
    logic [XW-1:0]    x_q, x_d, xp;
    logic [YW-1:0]    y_q, y_d, yp;
    logic             push, full, empty;
    logic             set_ovf, set_short, frame_done;
    cam_tag_t         wr_tag, rd_tag;
    logic [PIX_W+2:0] rd_word;

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        xp         = x_q;
        yp         = y_q;
        push       = 1'b0;
        wr_tag     = '0;
        set_ovf    = 1'b0;
        set_short  = 1'b0;
        frame_done = 1'b0;
        // Outside ACTIVE only an SOF pixel is of interest.
        if (pixel_valid && (state_q == ST_ACTIVE || pixel_sof)) begin
            if (full) begin
                set_ovf = 1'b1;
                state_d = ST_DROP;
            end else begin
                if (pixel_sof) begin
                    xp        = '0;
                    yp        = '0;
                    set_short = (state_q == ST_ACTIVE);
                end
                push       = 1'b1;
                wr_tag.sof = pixel_sof;
                wr_tag.eol = (xp == X_LAST);
                wr_tag.eof = wr_tag.eol && (yp == Y_LAST);
                x_d        = wr_tag.eol ? '0 : xp + 1'b1;
                y_d        = wr_tag.eol ? ((yp == Y_LAST) ? '0 : yp + 1'b1) : yp;
                frame_done = wr_tag.eof;
                state_d    = wr_tag.eof ? ST_WAIT_SOF : ST_ACTIVE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_WAIT_SOF;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    // Setting an error wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_count  <= '0;
            err_overflow <= 1'b0;
            err_short    <= 1'b0;
        end else begin
            if (frame_done) begin
                frame_count <= frame_count + 16'd1;
            end
            if (set_ovf) begin
                err_overflow <= 1'b1;
            end else if (err_clear) begin
                err_overflow <= 1'b0;
            end
            if (set_short) begin
                err_short <= 1'b1;
            end else if (err_clear) begin
                err_short <= 1'b0;
            end
        end
    end

    cam_fifo #(
        .WIDTH (PIX_W + 3),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({wr_tag, pixel_data}),
        .pop       (out_ready),
        .pop_data  (rd_word),
        .full      (full),
        .empty     (empty),
        .level     (fifo_level)
    );

    assign rd_tag    = rd_word[PIX_W+2:PIX_W];
    assign out_data  = rd_word[PIX_W-1:0];
    assign out_sof   = rd_tag.sof;
    assign out_eol   = rd_tag.eol;
    assign out_eof   = rd_tag.eof;
    assign out_valid = !empty;

endmodule

// File: tb/tb_camera_stream_in.sv
// Scoreboard bench for camera_stream_in with a small 4x2 frame and 4-deep buffer.
module tb_camera_stream_in;
    import cam_pkg::*;

    localparam int PIX_W = 24;
    localparam int IMG_W = 4;
    localparam int IMG_H = 2;
    localparam int DEPTH = 4;
    localparam int NPIX  = IMG_W * IMG_H;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [PIX_W-1:0] pixel_data = '0;
    logic             pixel_valid = 1'b0;
    logic             pixel_sof = 1'b0;
    logic [PIX_W-1:0] out_data;
    logic             out_sof, out_eol, out_eof, out_valid;
    logic             out_ready = 1'b0;
    logic [2:0]       fifo_level;
    logic [15:0]      frame_count;
    logic             err_overflow, err_short;
    logic             err_clear = 1'b0;

    camera_stream_in #(
        .PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pixel_data(pixel_data), .pixel_valid(pixel_valid),
        .pixel_sof(pixel_sof), .out_data(out_data), .out_sof(out_sof), .out_eol(out_eol),
        .out_eof(out_eof), .out_valid(out_valid), .out_ready(out_ready),
        .fifo_level(fifo_level), .frame_count(frame_count), .err_overflow(err_overflow),
        .err_short(err_short), .err_clear(err_clear)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: frame position as a linear pixel index.
    logic [PIX_W+2:0] expq[$];
    int          m_level  = 0;
    int          m_mode   = 0;   // 0 waiting for SOF, 1 in frame, 2 dropping
    int          m_pos    = 0;
    int unsigned m_frames = 0;
    bit          m_ovf    = 0;
    bit          m_short  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit v, input bit s, input logic [PIX_W-1:0] d,
                              input bit r, input bit clr);
        bit full, pop, eol, eof, sov, ssh;
        full = (m_level == DEPTH);
        pop  = (m_level > 0) && r;
        sov  = 0;
        ssh  = 0;
        if (v && (m_mode == 1 || s)) begin
            if (full) begin
                sov    = 1;
                m_mode = 2;
            end else begin
                if (s) begin
                    ssh   = (m_mode == 1);
                    m_pos = 0;
                end
                eol = (m_pos % IMG_W) == IMG_W - 1;
                eof = (m_pos == NPIX - 1);
                expq.push_back({s, eol, eof, d});
                m_level++;
                m_pos++;
                if (eof) begin
                    m_frames = (m_frames + 1) % 65536;
                    m_mode   = 0;
                end else begin
                    m_mode = 1;
                end
            end
        end
        if (pop) m_level--;
        if (sov) m_ovf = 1; else if (clr) m_ovf = 0;
        if (ssh) m_short = 1; else if (clr) m_short = 0;
    endtask

    task automatic check_state();
        cam_state_t es;
        es = (m_mode == 1) ? ST_ACTIVE : (m_mode == 2) ? ST_DROP : ST_WAIT_SOF;
        chk("fifo_level", 32'(fifo_level), 32'(m_level));
        chk("out_valid", 32'(out_valid), 32'(m_level != 0));
        chk("frame_count", 32'(frame_count), m_frames);
        chk("err_overflow", 32'(err_overflow), 32'(m_ovf));
        chk("err_short", 32'(err_short), 32'(m_short));
        chk("state", 32'(dut.state_q), 32'(es));
    endtask

    task automatic cycle(input bit v, input bit s, input logic [PIX_W-1:0] d,
                         input bit r, input bit clr);
        pixel_valid = v;
        pixel_sof   = s;
        pixel_data  = d;
        out_ready   = r;
        err_clear   = clr;
        @(posedge clk);
        model_step(v, s, d, r, clr);
        #1;
        check_state();
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && m_level != 0; i++) cycle(0, 0, '0, 1, 0);
        cycle(0, 0, '0, 1, 0);
        chk("drain_level", 32'(fifo_level), 0);
        chk("drain_pending", 32'(expq.size()), 0);
    endtask

    task automatic send_frame(input logic [PIX_W-1:0] base, input int n, input bit r);
        for (int i = 0; i < n; i++) cycle(1, i == 0, base + PIX_W'(i), r, 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_data"}, 32'(out_data), 0);
        chk({tag, "_tags"}, 32'({out_sof, out_eol, out_eof}), 0);
        chk({tag, "_valid"}, 32'(out_valid), 0);
        chk({tag, "_level"}, 32'(fifo_level), 0);
        chk({tag, "_frames"}, 32'(frame_count), 0);
        chk({tag, "_errs"}, 32'({err_overflow, err_short}), 0);
    endtask

    task automatic monitor();
        logic [PIX_W+2:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    chk("unexpected_output", {5'd0, out_sof, out_eol, out_eof, out_data}, 32'hFFFF_FFFF);
                end else begin
                    e = expq.pop_front();
                    chk("out_word", {5'd0, out_sof, out_eol, out_eof, out_data}, {5'd0, e});
                end
            end
        end
    endtask

    initial begin
        fork
            monitor();
        join_none
        #12;
        check_zero_outputs("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Junk before any SOF is discarded.
        for (int i = 0; i < 3; i++) cycle(1, 0, PIX_W'(24'hA0 + i), 1, 0);
        chk("junk_level", 32'(fifo_level), 0);

        // Full frame with free-flowing output.
        send_frame(24'h000001, NPIX, 1);
        drain();
        chk("frame1_count", 32'(frame_count), 1);

        // Backpressure: 5th pixel overflows, SOF while still full is dropped too.
        send_frame(24'h000100, 5, 0);
        chk("bp_ovf", 32'(err_overflow), 1);
        chk("bp_state", 32'(dut.state_q), 32'(ST_DROP));
        cycle(1, 1, 24'h0001FF, 0, 0);
        drain();
        cycle(0, 0, '0, 1, 1);
        chk("ovf_cleared", 32'(err_overflow), 0);
        send_frame(24'h000200, NPIX, 1);
        drain();

        // Overflow in the same cycle as a clear keeps the flag set.
        send_frame(24'h000300, 4, 0);
        cycle(1, 0, 24'h000304, 0, 1);
        chk("race_ovf", 32'(err_overflow), 1);
        cycle(0, 0, '0, 0, 1);
        chk("clear_alone", 32'(err_overflow), 0);
        drain();

        // Short frame then a complete one.
        send_frame(24'h000400, 4, 1);
        send_frame(24'h000500, NPIX, 1);
        chk("short_flag", 32'(err_short), 1);
        drain();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
                  PIX_W'($urandom), $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
        end
        drain();

        // Mid-frame reset discards buffered pixels.
        send_frame(24'h000600, 5, 0);
        rst_n = 1'b0;
        #1;
        expq.delete();
        m_level = 0; m_mode = 0; m_pos = 0; m_frames = 0; m_ovf = 0; m_short = 0;
        check_zero_outputs("midreset");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        send_frame(24'h000700, NPIX, 1);
        drain();
        chk("post_reset_frames", 32'(frame_count), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
